// File: rtl/pwm_multichannel.sv
// pwm_multichannel: multi-channel PWM generator sharing one period counter.
//
// Duty words arrive on a valid/ready port. Each accepted word is scaled to a
// clock-count threshold by a sequential shift-add multiplier, parked in a
// per-channel pending buffer, and copied into the active threshold only at
// that channel's own period boundary. Outputs therefore never glitch
// mid-period. With PHASE_STAGGER=1, channel i runs (i*PERIOD)/CHANNELS clocks
// ahead of the shared counter.
//
// Derived PERIOD = PERIOD_NS*SYS_FREQ_MHZ/1000 clocks and must be >= 2.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   wr_valid     in   duty write request
//   wr_ready     out  block can accept a write (low while a write is scaled)
//   wr_chan      in   target channel index
//   wr_duty      in   new duty value, full scale = 2^DUTY_BITS-1
//   wr_err       out  one-cycle pulse after accepting a write to a missing channel
//   ch_en        in   per-channel output enable
//   pwm_out      out  registered PWM outputs
//   period_start out  one-cycle pulse aligned with pwm_out of the cnt==0 cycle
module pwm_multichannel #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned DUTY_BITS     = 10,
    parameter int unsigned PERIOD_NS     = 20000000,
    parameter int unsigned SYS_FREQ_MHZ  = 100,
    parameter int unsigned PHASE_STAGGER = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [3:0]           wr_chan,
    input  logic [DUTY_BITS-1:0] wr_duty,
    output logic                 wr_err,
    input  logic [CHANNELS-1:0]  ch_en,
    output logic [CHANNELS-1:0]  pwm_out,
    output logic                 period_start
);

    // 64-bit arithmetic so that PERIOD_NS*SYS_FREQ_MHZ cannot overflow.
    localparam logic [63:0] PeriodL = (64'(PERIOD_NS) * 64'(SYS_FREQ_MHZ)) / 64'd1000;
    localparam int unsigned Period  = 32'(PeriodL);
    localparam int unsigned CntW    = $clog2(Period) + 1;
    localparam int unsigned AccW    = DUTY_BITS + CntW;
    localparam int unsigned StepW   = $clog2(DUTY_BITS) + 1;

    localparam logic [CntW-1:0]  PeriodC = CntW'(Period);
    localparam logic [CntW-1:0]  LastC   = CntW'(Period - 1);
    localparam logic [AccW-1:0]  PeriodA = AccW'(Period);
    localparam logic [StepW-1:0] LastStp = StepW'(DUTY_BITS - 1);
    localparam logic [4:0]       NumCh   = 5'(CHANNELS);

    function automatic logic [CntW-1:0] chan_offset(input int unsigned idx);
        logic [63:0] off;
        off = (PHASE_STAGGER != 0) ? (64'(idx) * PeriodL) / 64'(CHANNELS) : 64'd0;
        return CntW'(off);
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StCommit
    } wr_state_e;

    // ------------------------------------------------------------------
    // Shared period counter
    // ------------------------------------------------------------------
    logic [CntW-1:0] cnt_q, cnt_d;

    assign cnt_d = (cnt_q == LastC) ? '0 : cnt_q + 1'b1;

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    wr_state_e            state_q, state_d;
    logic [3:0]           chan_q, chan_d;
    logic [DUTY_BITS-1:0] dsr_q, dsr_d;    // duty bits, consumed MSB first
    logic                 full_q, full_d;  // duty was full scale: force 100%
    logic [AccW-1:0]      acc_q, acc_d;
    logic [StepW-1:0]     step_q, step_d;
    logic                 err_q, err_d;
    logic                 commit;
    logic [CntW-1:0]      mul_thr;

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    logic [CntW-1:0]     thr_q  [CHANNELS];
    logic [CntW-1:0]     pend_q [CHANNELS];
    logic [CHANNELS-1:0] pflag_q;
    logic [CntW-1:0]     ph     [CHANNELS];
    logic [CntW-1:0]     thr_eff[CHANNELS];
    logic [CHANNELS-1:0] bnd;
    logic [CHANNELS-1:0] pwm_d;
    logic [CHANNELS-1:0] pwm_q;
    logic                ps_q;

    // ------------------------------------------------------------------
    // Write FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        dsr_d   = dsr_q;
        full_d  = full_q;
        acc_d   = acc_q;
        step_d  = step_q;
        err_d   = 1'b0;
        commit  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (wr_valid) begin
                    if ({1'b0, wr_chan} >= NumCh) begin
                        // Accepted but dropped: no multiply, no state change.
                        err_d = 1'b1;
                    end else begin
                        chan_d  = wr_chan;
                        dsr_d   = wr_duty;
                        full_d  = &wr_duty;
                        acc_d   = '0;
                        step_d  = '0;
                        state_d = StMul;
                    end
                end
            end
            StMul: begin
                // MSB-first shift-add: acc = 2*acc + bit*PERIOD.
                acc_d  = {acc_q[AccW-2:0], 1'b0} + (dsr_q[DUTY_BITS-1] ? PeriodA : '0);
                dsr_d  = dsr_q << 1;
                step_d = step_q + 1'b1;
                if (step_q == LastStp) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                commit  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // acc holds duty*PERIOD; the >>DUTY_BITS is a plain slice.
    assign mul_thr  = full_q ? PeriodC : acc_q[AccW-1:DUTY_BITS];
    assign wr_ready = (state_q == StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            chan_q  <= '0;
            dsr_q   <= '0;
            full_q  <= 1'b0;
            acc_q   <= '0;
            step_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            dsr_q   <= dsr_d;
            full_q  <= full_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel phase, boundary detect and compare
    // ------------------------------------------------------------------
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [CntW-1:0] Off = chan_offset(i);
        logic [CntW-1:0] sum;

        // cnt and Off are both < PERIOD, so one conditional subtract wraps.
        assign sum        = cnt_q + Off;
        assign ph[i]      = (sum >= PeriodC) ? sum - PeriodC : sum;
        assign bnd[i]     = (ph[i] == '0);
        // A pending value takes over already in its boundary cycle, so it
        // governs the whole period that starts there.
        assign thr_eff[i] = (bnd[i] && pflag_q[i]) ? pend_q[i] : thr_q[i];
        assign pwm_d[i]   = ch_en[i] & (ph[i] < thr_eff[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pflag_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                thr_q[i]  <= '0;
                pend_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bnd[i] && pflag_q[i]) begin
                    thr_q[i]   <= pend_q[i];
                    pflag_q[i] <= 1'b0;
                end
                // Ordered after the apply so a same-cycle commit keeps its
                // flag and lands at the following boundary.
                if (commit && (chan_q == 4'(i))) begin
                    pend_q[i]  <= mul_thr;
                    pflag_q[i] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            pwm_q <= '0;
            ps_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
            ps_q  <= (cnt_q == '0);
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign wr_err       = err_q;

endmodule
